dm_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port. Sits between the MEM stage and the word-wide DM RAM.

---
 rtl/dm_access_pkg.sv | 42 ++++
 rtl/dm_access_ctrl_if.sv | 33 +++
 rtl/dm_byte_lane.sv | 54 +++++
 rtl/dm_access_ctrl.sv | 99 +++++++++
 tb/tb_dm_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_access_pkg.sv
// Shared types and constants for the data-memory access controller.
// Combinational only; no latency.
// No flow control of its own.
package dm_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int unsigned DM_BYTES_DEFAULT = 12288;
    localparam int unsigned ADDR_LSB         = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK_FAIL = 3'd1,
        ST_LOAD       = 3'd2,
        ST_RMW_READ   = 3'd3,
        ST_WRITE      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Request fields captured on the accept edge.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    // Misaligned, illegal-size or beyond-the-last-byte requests never reach DM.
    function automatic logic req_bad(input logic [31:0] addr, input logic [1:0] size,
                                     input logic [31:0] last_addr);
        return (size == SIZE_ILLEGAL) ||
               ((size == SIZE_HALF) && addr[0]) ||
               ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
               (addr > last_addr);
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Pipeline request/response and DM word-port signals of the access controller.
// Wires only; no latency.
// Pipeline stalls while req_ready is low; DM is always ready.
interface dm_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [31:0] dm_pc;

    // Controller view.
    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, dm_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_wdata, dm_pc
    );

    // Pipeline + DM RAM view.
    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, dm_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, dm_we, dm_addr, dm_wdata, dm_pc
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Byte/half lane extraction with sign/zero extension, and sub-word merge into a word.
// Purely combinational; zero latency.
// No flow control.
module dm_byte_lane
    import dm_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] ext_word,
    output logic [31:0] merged_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane (little-endian) and extend it to 32 bits.
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: ext_word = {{24{sext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: ext_word = {{16{sext & half_sel[15]}}, half_sel};
            default:   ext_word = word;
        endcase
    end

    // Replace only the addressed lane(s) of the current word with the store data.
    always_comb begin
        merged_word = word;
        case (size)
            SIZE_BYTE: begin
                case (addr_lo)
                    2'd1:    merged_word[15:8]  = data[7:0];
                    2'd2:    merged_word[23:16] = data[7:0];
                    2'd3:    merged_word[31:24] = data[7:0];
                    default: merged_word[7:0]   = data[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo[1]) merged_word[31:16] = data[15:0];
                else            merged_word[15:0]  = data[15:0];
            end
            default: merged_word = data;
        endcase
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage to DM word-port controller: byte/half/word loads, word stores, RMW sub-word stores.
// Response 3 cycles after accept (4 for sub-word stores); one request in flight at a time.
// req_ready only in IDLE with no response pending, so throughput is 1 per 4 (5) cycles.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int unsigned DM_BYTES = DM_BYTES_DEFAULT
) (
    input  logic            clk,
    input  logic            RESET,
    dm_access_ctrl_if.slave bus
);
    localparam logic [31:0] LAST_ADDR = 32'(DM_BYTES - 1);
    localparam logic [31:0] WORD_MASK = ~((32'd1 << ADDR_LSB) - 32'd1);

    state_t      state_q, state_d;
    req_t        req_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        accept;
    logic        bad;
    logic [31:0] lane_ext;
    logic [31:0] lane_merge;

    // The response cycle also keeps ready low so a response and the next accept never overlap.
    assign bus.req_ready = (state_q == ST_IDLE) & ~resp_valid_q & ~RESET;
    assign accept        = bus.req_valid & bus.req_ready;
    assign bad           = req_bad(bus.req_addr, bus.req_size, LAST_ADDR);

    assign bus.dm_we      = (state_q == ST_WRITE) & ~RESET;
    assign bus.dm_addr    = req_q.addr & WORD_MASK;
    assign bus.dm_wdata   = req_q.wdata;
    assign bus.dm_pc      = req_q.pc;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;

    dm_byte_lane u_lane (
        .word        (bus.dm_rdata),
        .data        (req_q.wdata),
        .addr_lo     (req_q.addr[1:0]),
        .size        (req_q.size),
        .sext        (req_q.sext),
        .ext_word    (lane_ext),
        .merged_word (lane_merge)
    );

    // Next-state selection; errors bypass every DM access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad)                            state_d = ST_CHECK_FAIL;
                    else if (!bus.req_we)               state_d = ST_LOAD;
                    else if (bus.req_size == SIZE_WORD) state_d = ST_WRITE;
                    else                                state_d = ST_RMW_READ;
                end
            end
            ST_CHECK_FAIL: state_d = ST_DONE;
            ST_LOAD:       state_d = ST_DONE;
            ST_RMW_READ:   state_d = ST_WRITE;
            ST_WRITE:      state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // State, request latch, load result / merged word, and registered response.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_q == ST_DONE);
            resp_err_q   <= (state_q == ST_DONE) & err_q;
            if (accept) begin
                req_q <= '{we: bus.req_we, size: bus.req_size, sext: bus.req_sext,
                           addr: bus.req_addr, wdata: bus.req_wdata, pc: bus.req_pc};
                rdata_q <= '0;
                err_q   <= bad;
            end
            if (state_q == ST_LOAD) begin
                rdata_q <= lane_ext;
            end
            // The merged word replaces the store data so WRITE always drives req_q.wdata.
            if (state_q == ST_RMW_READ) begin
                req_q.wdata <= lane_merge;
            end
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a byte-array reference memory.
// Directed scenarios followed by randomized requests.
// Pipeline side honours req_ready; DM RAM model is always ready.
module tb_dm_access_ctrl;
    import dm_access_pkg::*;

    localparam int DMB = 12288;

    logic clk = 1'b0;
    logic RESET;
    logic init_mem;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:DMB/4-1];
    logic [7:0]  ref_mem [0:DMB-1];

    always #5 clk = ~clk;

    dm_access_ctrl_if bus();

    dm_access_ctrl #(.DM_BYTES(DMB)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // DM RAM: combinational read, write on posedge when dm_we.
    assign bus.dm_rdata = (bus.dm_addr < 32'(DMB)) ? mem[bus.dm_addr[13:2]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int w = 0; w < DMB/4; w++) mem[w] <= init_word(w);
        end else if (bus.dm_we && (bus.dm_addr < 32'(DMB))) begin
            mem[bus.dm_addr[13:2]] <= bus.dm_wdata;
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Reference: byte-granular memory, rules applied directly to byte counts.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic er, output int lat);
        int unsigned n;
        logic [63:0] v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        er  = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'(DMB));
        rd  = 32'h0;
        lat = 3;
        if (er) return;
        if (!we) begin
            v = 64'h0;
            for (int unsigned i = 0; i < n; i++) v = v | (64'(ref_mem[addr+i]) << (8*i));
            if (sext && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            rd = v[31:0];
        end else begin
            for (int unsigned i = 0; i < n; i++) ref_mem[addr+i] = 8'(wdata >> (8*i));
            if (n < 4) lat = 4;
        end
    endtask

    // Issue one request and observe: latency in cycles after accept, DM writes seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwe, output logic [31:0] wa, output logic [31:0] wpc);
        int n;
        lat = -1; nwe = 0; rd = 32'h0; er = 1'b0; wa = 32'h0; wpc = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_sext = sext;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_pc = pc;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
        bus.req_sext = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_pc = $urandom;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.dm_we) begin
                nwe++;
                wa  = bus.dm_addr;
                wpc = bus.dm_pc;
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", bus.req_ready); end
        @(posedge clk); #1;
        RESET = 1'b0; init_mem = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", bus.resp_err); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", bus.resp_rdata); end
        checks++; if (bus.dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we got %b want 0", bus.dm_we); end
        checks++; if ({bus.dm_addr, bus.dm_wdata, bus.dm_pc} !== 96'h0) begin errors++; $display("FAIL reset_dm_regs got %h %h %h want 0", bus.dm_addr, bus.dm_wdata, bus.dm_pc); end
    endtask

    task automatic test_word;
        logic [31:0] rd, wa, wpc, mrd; logic er, mer; int lat, mlat, nwe;
        ref_access(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, mrd, mer, mlat);
        do_req(1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h3000, rd, er, lat, nwe, wa, wpc);
        checks++; if (nwe !== 1 || wa !== 32'h10 || wpc !== 32'h3000) begin errors++; $display("FAIL word_store_dm nwe=%0d addr=%h pc=%h want 1 10 3000", nwe, wa, wpc); end
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL word_store_resp lat=%0d err=%b want 3 0", lat, er); end
        ref_access(0, SIZE_WORD, 0, 32'h10, 32'h0, mrd, mer, mlat);
        do_req(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h3004, rd, er, lat, nwe, wa, wpc);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3 || nwe !== 0) begin errors++; $display("FAIL word_load got %h err=%b lat=%0d nwe=%0d want deadbeef 0 3 0", rd, er, lat, nwe); end
    endtask

    task automatic test_byte;
        logic [31:0] rd, wa, wpc, mrd; logic er, mer; int lat, mlat, nwe;
        ref_access(1, SIZE_WORD, 0, 32'h10, 32'h11223344, mrd, mer, mlat);
        do_req(1, SIZE_WORD, 0, 32'h10, 32'h11223344, 32'h3008, rd, er, lat, nwe, wa, wpc);
        ref_access(1, SIZE_BYTE, 0, 32'h11, 32'h000000AA, mrd, mer, mlat);
        do_req(1, SIZE_BYTE, 0, 32'h11, 32'hFFFFFFAA, 32'h300C, rd, er, lat, nwe, wa, wpc);
        checks++; if (lat !== 4 || nwe !== 1 || wa !== 32'h10 || er !== 1'b0) begin errors++; $display("FAIL byte_store lat=%0d nwe=%0d addr=%h err=%b want 4 1 10 0", lat, nwe, wa, er); end
        checks++; if (mem[4] !== 32'h1122AA44) begin errors++; $display("FAIL byte_store_word got %h want 1122aa44", mem[4]); end
        do_req(0, SIZE_BYTE, 1, 32'h11, 32'h0, 32'h3010, rd, er, lat, nwe, wa, wpc);
        checks++; if (rd !== 32'hFFFFFFAA || er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL byte_load_sext got %h err=%b lat=%0d want ffffffaa 0 3", rd, er, lat); end
        do_req(0, SIZE_BYTE, 0, 32'h11, 32'h0, 32'h3014, rd, er, lat, nwe, wa, wpc);
        checks++; if (rd !== 32'h000000AA || er !== 1'b0) begin errors++; $display("FAIL byte_load_zext got %h err=%b want 000000aa 0", rd, er); end
    endtask

    task automatic test_half;
        logic [31:0] rd, wa, wpc, mrd; logic er, mer; int lat, mlat, nwe, word_lat;
        ref_access(1, SIZE_WORD, 0, 32'h10, 32'h11223344, mrd, mer, mlat);
        do_req(1, SIZE_WORD, 0, 32'h10, 32'h11223344, 32'h3018, rd, er, word_lat, nwe, wa, wpc);
        ref_access(1, SIZE_HALF, 0, 32'h12, 32'h00008001, mrd, mer, mlat);
        do_req(1, SIZE_HALF, 0, 32'h12, 32'h12348001, 32'h301C, rd, er, lat, nwe, wa, wpc);
        checks++; if (lat !== word_lat + 1 || nwe !== 1) begin errors++; $display("FAIL half_store_latency got %0d (word %0d) nwe=%0d want word+1 1", lat, word_lat, nwe); end
        checks++; if (mem[4] !== 32'h80013344) begin errors++; $display("FAIL half_store_word got %h want 80013344", mem[4]); end
        do_req(0, SIZE_HALF, 1, 32'h12, 32'h0, 32'h3020, rd, er, lat, nwe, wa, wpc);
        checks++; if (rd !== 32'hFFFF8001 || er !== 1'b0) begin errors++; $display("FAIL half_load_sext got %h err=%b want ffff8001 0", rd, er); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, wa, wpc, mrd, w4, w5; logic er, mer; int lat, mlat, nwe;
        logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  t_size [3] = '{SIZE_WORD, SIZE_HALF, SIZE_WORD};
        logic [31:0] t_addr [3] = '{32'h13, 32'h15, 32'h3000};
        w4 = mem[4]; w5 = mem[5];
        for (int i = 0; i < 3; i++) begin
            ref_access(t_we[i], t_size[i], 0, t_addr[i], 32'hCAFEF00D, mrd, mer, mlat);
            do_req(t_we[i], t_size[i], 0, t_addr[i], 32'hCAFEF00D, 32'h4000, rd, er, lat, nwe, wa, wpc);
            checks++; if (er !== 1'b1 || rd !== 32'h0 || nwe !== 0 || lat !== 3) begin errors++; $display("FAIL error_req%0d err=%b rdata=%h nwe=%0d lat=%0d want 1 0 0 3", i, er, rd, nwe, lat); end
        end
        checks++; if (mem[4] !== w4 || mem[5] !== w5) begin errors++; $display("FAIL error_mem got %h %h want %h %h", mem[4], mem[5], w4, w5); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w8; int nwe, nresp;
        w8 = mem[8];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SIZE_BYTE; bus.req_sext = 1'b0;
        bus.req_addr = 32'h21; bus.req_wdata = 32'h5C; bus.req_pc = 32'h5000;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        RESET = 1'b1;
        @(posedge clk); #1;
        RESET = 1'b0;
        nwe = 0; nresp = 0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", bus.req_ready); end
        for (int c = 0; c < 8; c++) begin
            if (bus.dm_we) nwe++;
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        checks++; if (nwe !== 0 || nresp !== 0) begin errors++; $display("FAIL reset_mid_activity dm_we=%0d resp=%0d want 0 0", nwe, nresp); end
        checks++; if (mem[8] !== w8 || mem[8] !== ref_word(32'h20)) begin errors++; $display("FAIL reset_mid_mem got %h want %h", mem[8], w8); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [3]; logic [31:0] exp_rd [3]; logic [31:0] got [3];
        int t [3]; logic er; int lat, idx, nresp;
        for (int i = 0; i < 3; i++) begin
            a[i] = 32'($urandom_range(0, DMB/4 - 1)) * 32'd4;
            ref_access(0, SIZE_WORD, 0, a[i], 32'h0, exp_rd[i], er, lat);
            t[i] = 0; got[i] = 32'h0;
        end
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = SIZE_WORD; bus.req_sext = 1'b0; bus.req_pc = 32'h6000;
        bus.req_addr = a[0]; bus.req_valid = 1'b1;
        idx = 0; nresp = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.resp_valid) begin
                if (nresp < 3) begin t[nresp] = c; got[nresp] = bus.resp_rdata; end
                nresp++;
            end
            if (idx < 3 && bus.req_ready) begin
                @(posedge clk); #1;
                idx++;
                if (idx < 3) bus.req_addr = a[idx];
                else         bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++; if (nresp !== 3 || idx !== 3) begin errors++; $display("FAIL b2b_count resp=%0d accepts=%0d want 3 3", nresp, idx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== exp_rd[i]) begin errors++; $display("FAIL b2b_rdata%0d got %h want %h", i, got[i], exp_rd[i]); end
        end
        checks++; if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin errors++; $display("FAIL b2b_spacing got %0d %0d want 4 4", t[1] - t[0], t[2] - t[1]); end
    endtask

    task automatic test_random;
        logic [31:0] addr, wdata, rd, wa, wpc, mrd; logic [1:0] size; logic we, sext, er, mer;
        int lat, mlat, nwe, r;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom);
            sext  = 1'($urandom);
            size  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            r     = $urandom_range(0, 9);
            if (r == 0) addr = 32'(DMB) + 32'($urandom_range(0, 4000));
            else        addr = 32'($urandom_range(0, DMB - 1));
            if (r > 2 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            ref_access(we, size, sext, addr, wdata, mrd, mer, mlat);
            do_req(we, size, sext, addr, wdata, $urandom, rd, er, lat, nwe, wa, wpc);
            checks++; if (er !== mer || rd !== mrd || lat !== mlat) begin errors++; $display("FAIL rand%0d we=%b size=%0d addr=%h got rd=%h err=%b lat=%0d want %h %b %0d", i, we, size, addr, rd, er, lat, mrd, mer, mlat); end
            checks++; if (nwe !== ((we && !mer) ? 1 : 0) || (nwe == 1 && wa !== (addr & 32'hFFFF_FFFC))) begin errors++; $display("FAIL rand%0d_dm_we count=%0d addr=%h want %0d %h", i, nwe, wa, (we && !mer) ? 1 : 0, addr & 32'hFFFF_FFFC); end
            if (we && !mer) begin
                checks++; if (mem[addr[13:2]] !== ref_word(addr)) begin errors++; $display("FAIL rand%0d_mem got %h want %h", i, mem[addr[13:2]], ref_word(addr)); end
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        RESET = 1'b1; init_mem = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_sext = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_pc = 32'h0;
        for (int i = 0; i < DMB/4; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
